// File: rtl/ifetch_queue_if.sv
// ---------------------------------------------------------------------------
// ifetch_queue_if
// Bundle of the IF -> queue -> ID handshake signals for ifetch_queue.
//
// Handshake semantics (both sides): a transfer happens on a rising clock edge
// when the producer's valid and the consumer's allow_in are both high in that
// cycle. A producer holding valid may not withdraw or change its data until
// the transfer completes (or a flush discards it).
//
//   in_valid     IF offers in_data
//   in_allow_in  queue accepts in_data this cycle
//   in_data      fetch bundle from IF
//   out_valid    head entry (or bypassed in_data) available to ID
//   out_allow_in ID accepts out_data this cycle
//   out_data     head entry / bypassed in_data
//   flush        discard all entries (branch redirect)
//   count        occupancy
//   full, empty  occupancy decodes
//
// modport master : the side driving IF/ID/flush (testbench or pipeline glue)
// modport slave  : the queue itself
// ---------------------------------------------------------------------------
interface ifetch_queue_if #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 64
);
    localparam int CW = $clog2(DEPTH + 1);

    logic              in_valid;
    logic              in_allow_in;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_allow_in;
    logic [DATA_W-1:0] out_data;
    logic              flush;
    logic [CW-1:0]     count;
    logic              full;
    logic              empty;

    modport master (
        output in_valid, in_data, out_allow_in, flush,
        input  in_allow_in, out_valid, out_data, count, full, empty
    );

    modport slave (
        input  in_valid, in_data, out_allow_in, flush,
        output in_allow_in, out_valid, out_data, count, full, empty
    );
endinterface

// File: rtl/ifetch_queue.sv
// ---------------------------------------------------------------------------
// ifetch_queue
// DEPTH-entry instruction-fetch buffer between IF and ID, so IF can keep
// fetching while ID stalls. Supports a flush for branch redirect and, with
// BYPASS=1, same-cycle forwarding of in_data when the queue is empty.
//
// Ports:
//   clk    sole clock, rising edge
//   reset  synchronous, active-high; has priority over flush
//   q      ifetch_queue_if.slave (in_*/out_* handshakes, flush, count,
//          full, empty)
//
// Parameters:
//   DEPTH  entries, power of two, >= 2
//   DATA_W entry width ({pc, inst} by default)
//   BYPASS 1 = empty queue forwards in_data combinationally
// ---------------------------------------------------------------------------
module ifetch_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 64,
    parameter int BYPASS = 0
) (
    input  logic            clk,
    input  logic            reset,
    ifetch_queue_if.slave   q
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;

    logic w_bypass_en;
    logic w_empty;
    logic w_full;
    logic w_bypass_hit;
    logic w_push;
    logic w_pop;
    logic w_in_allow_in;
    logic w_out_valid;

    assign w_bypass_en = (BYPASS != 0);
    assign w_empty     = (r_count == '0);
    assign w_full      = (r_count == CW'(DEPTH));

    // Bypassed entries go straight from IF to ID; queue state is untouched.
    assign w_bypass_hit = w_bypass_en & w_empty & q.in_valid & q.out_allow_in & ~q.flush;

    // When full, a pop in the same cycle frees the slot the push will use.
    assign w_in_allow_in = ~q.flush & ~reset & (~w_full | q.out_allow_in);
    assign w_out_valid   = ~q.flush & (~w_empty | (w_bypass_en & q.in_valid));

    assign w_push = q.in_valid & w_in_allow_in & ~w_bypass_hit;
    assign w_pop  = w_out_valid & q.out_allow_in & ~w_bypass_hit;

    assign q.in_allow_in = w_in_allow_in;
    assign q.out_valid   = w_out_valid;
    assign q.out_data    = w_empty ? q.in_data : r_mem[r_rd_ptr];
    assign q.count       = r_count;
    assign q.full        = w_full;
    assign q.empty       = w_empty;

    // Pointer/occupancy state. Pointers wrap by natural overflow; count is
    // kept separately so full and empty are unambiguous.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (q.flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is not reset; contents are don't-care while empty. w_push is
    // already gated by reset and flush through in_allow_in.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= q.in_data;
        end
    end

    a_count_bound: assert property (@(posedge clk) disable iff (reset)
        r_count <= CW'(DEPTH));
    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(w_push && w_full && !w_pop));
    a_no_underflow: assert property (@(posedge clk) disable iff (reset)
        !(w_pop && w_empty));
    a_full_empty: assert property (@(posedge clk) disable iff (reset)
        !(w_full && w_empty));

endmodule
